if_id_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 8-bit pipelined core.
- Owns the PC and drives the instruction-memory address.
- Latches the fetched instruction and splits it into the fields consumed by the immediate generator and decode: imm, relAdd, jumpIns_ctrl.
- Handles stall, jump redirect/flush and halt.

---
 rtl/if_id_stage.sv | 152 +++++++++++++++
 tb/tb_if_id_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: instruction-fetch stage plus IF/ID pipeline register for the
// 8-bit pipelined core.
//
// Owns the PC and drives the instruction-memory address. The fetched
// instruction is latched into IF/ID and sliced into the fields used by the
// immediate generator and decode. Handles stall, jump redirect/flush and
// halt.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   imemAddr        instruction-memory address (current PC)
//   imemData        instruction at imemAddr, combinational, same cycle
//   stall           hold PC and IF/ID contents
//   jumpTaken       redirect fetch to jumpTarget (overrides stall)
//   jumpTarget      redirect address
//   instr_ID        latched instruction
//   pc_ID           PC of the latched instruction
//   valid_ID        IF/ID holds a real instruction (0 = bubble)
//   imm, relAdd     instr_ID[2:0], instr_ID[5:0]
//   jumpIns_ctrl    latched instruction is a valid, non-halt jump
//   halted          core is in the HALTED state
//   state_dbg       FSM state (0 BOOT, 1 RUN, 2 HALTED)
//
// Optional feature, macro IF_PERF_CNT_EN:
//   fetchCnt[15:0]  saturating count of RUN-state latches with valid_ID<=1
//   stallCnt[15:0]  saturating count of cycles with stall=1 and no jump
//
// Handshake note: there is no valid/ready pair here. stall is a hold
// request from the hazard unit; jumpTaken is a one-cycle redirect command
// that wins over stall. valid_ID marks whether IF/ID carries a real
// instruction to the downstream stage.
module if_id_stage #(
  parameter int unsigned          PC_W       = 8,
  parameter int unsigned          INSTR_W    = 8,
  parameter logic [1:0]           JUMP_OP    = 2'b11,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = 8'hC0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imemAddr,
  input  logic [INSTR_W-1:0] imemData,
  input  logic               stall,
  input  logic               jumpTaken,
  input  logic [PC_W-1:0]    jumpTarget,
  output logic [INSTR_W-1:0] instr_ID,
  output logic [PC_W-1:0]    pc_ID,
  output logic               valid_ID,
  output logic [2:0]         imm,
  output logic [5:0]         relAdd,
  output logic               jumpIns_ctrl,
  output logic               halted,
`ifdef IF_PERF_CNT_EN
  output logic [15:0]        fetchCnt,
  output logic [15:0]        stallCnt,
`endif
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc;

  // A plain fetch-and-latch happens only in RUN with no redirect and no hold.
  logic fetch_en;
  assign fetch_en = (state == RUN) && !jumpTaken && !stall;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (fetch_en && (imemData == HALT_INSTR)) state_nxt = HALTED;
      HALTED:  if (jumpTaken) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Output logic (state-derived)
  always_comb begin
    halted    = (state == HALTED);
    state_dbg = state;
  end

  // PC and IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      instr_ID <= '0;
      pc_ID    <= '0;
      valid_ID <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (jumpTaken) begin
            pc       <= jumpTarget;
            valid_ID <= 1'b0;
          end else if (!stall) begin
            instr_ID <= imemData;
            pc_ID    <= pc;
            valid_ID <= 1'b1;
            // Halt freezes the PC on the halt instruction itself.
            if (imemData != HALT_INSTR) pc <= pc + 1'b1;
          end
        end
        HALTED: begin
          // Wrong-path halt: an older jump resolves and restarts fetch.
          if (jumpTaken) begin
            pc       <= jumpTarget;
            valid_ID <= 1'b0;
          end else if (!stall) begin
            valid_ID <= 1'b0;
          end
        end
        default: ; // BOOT: present address 0, latch nothing
      endcase
    end
  end

  assign imemAddr     = pc;
  assign imm          = instr_ID[2:0];
  assign relAdd       = instr_ID[5:0];
  // Gated by valid_ID so a flushed slot with stale contents is never a jump.
  assign jumpIns_ctrl = valid_ID && (instr_ID[7:6] == JUMP_OP) &&
                        (instr_ID != HALT_INSTR);

`ifdef IF_PERF_CNT_EN
  logic stall_cycle;
  assign stall_cycle = stall && !jumpTaken && ((state == RUN) || (state == HALTED));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchCnt <= '0;
      stallCnt <= '0;
    end else begin
      if (fetch_en && (fetchCnt != 16'hFFFF)) fetchCnt <= fetchCnt + 16'd1;
      if (stall_cycle && (stallCnt != 16'hFFFF)) stallCnt <= stallCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] imemAddr;
  logic [7:0] imemData;
  logic       stall;
  logic       jumpTaken;
  logic [7:0] jumpTarget;
  logic [7:0] instr_ID;
  logic [7:0] pc_ID;
  logic       valid_ID;
  logic [2:0] imm;
  logic [5:0] relAdd;
  logic       jumpIns_ctrl;
  logic       halted;
  logic [1:0] state_dbg;
`ifdef IF_PERF_CNT_EN
  logic [15:0] fetchCnt;
  logic [15:0] stallCnt;
`endif

  logic [7:0] imem [256];

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign imemData = imem[imemAddr];

  if_id_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imemAddr    (imemAddr),
    .imemData    (imemData),
    .stall       (stall),
    .jumpTaken   (jumpTaken),
    .jumpTarget  (jumpTarget),
    .instr_ID    (instr_ID),
    .pc_ID       (pc_ID),
    .valid_ID    (valid_ID),
    .imm         (imm),
    .relAdd      (relAdd),
    .jumpIns_ctrl(jumpIns_ctrl),
    .halted      (halted),
`ifdef IF_PERF_CNT_EN
    .fetchCnt    (fetchCnt),
    .stallCnt    (stallCnt),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- driver tasks ----------------
  // Advance one rising edge, then settle 1 time unit before driving/sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the full IF/ID view at once.
  task automatic check_ifid(input string tag, input logic [7:0] e_addr,
                            input logic [7:0] e_instr, input logic [7:0] e_pc,
                            input logic e_valid);
    check({tag, ".imemAddr"}, 16'(imemAddr), 16'(e_addr));
    check({tag, ".instr_ID"}, 16'(instr_ID), 16'(e_instr));
    check({tag, ".pc_ID"},    16'(pc_ID),    16'(e_pc));
    check({tag, ".valid_ID"}, 16'(valid_ID), 16'(e_valid));
    check({tag, ".imm"},      16'(imm),      16'(e_instr[2:0]));
    check({tag, ".relAdd"},   16'(relAdd),   16'(e_instr[5:0]));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'(i + 8'h10);
    rst = 1'b1; stall = 1'b0; jumpTaken = 1'b0; jumpTarget = 8'h00;
    step(); step();

    // Reset state
    check_ifid("rst", 8'h00, 8'h00, 8'h00, 1'b0);
    check("rst.halted", 16'(halted), 16'd0);
    check("rst.jmp", 16'(jumpIns_ctrl), 16'd0);
    check("rst.state", 16'(state_dbg), 16'd0);

    // BOOT cycle
    rst = 1'b0;
    check_ifid("boot", 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    check("run.state", 16'(state_dbg), 16'd1);
    check_ifid("run0", 8'h00, 8'h00, 8'h00, 1'b0);

    // Straight-line fetch: instr = pc + 0x10
    for (int i = 0; i < 5; i++) begin
      step();
      check_ifid("seq", 8'(i + 1), 8'(i + 8'h10), 8'(i), 1'b1);
    end

    // Stall 3 cycles with PC=5
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("stall", 8'h05, 8'h14, 8'h04, 1'b1);
    end
    stall = 1'b0;
    step();
    check_ifid("resume", 8'h06, 8'h15, 8'h05, 1'b1);

    // Jump with simultaneous stall: jump wins, flush
    imem[8'h41] = 8'hC5;
    stall = 1'b1; jumpTaken = 1'b1; jumpTarget = 8'h40;
    step();
    check_ifid("jmpstall", 8'h40, 8'h15, 8'h05, 1'b0);
    stall = 1'b0; jumpTaken = 1'b0;
    step();
    check_ifid("jmptgt", 8'h41, 8'h50, 8'h40, 1'b1);

    // Jump instruction 0xC5 latched
    step();
    check_ifid("jins", 8'h42, 8'hC5, 8'h41, 1'b1);
    check("jins.ctrl", 16'(jumpIns_ctrl), 16'd1);

    // Redirect to 7: bubble with stale 0xC5 must not look like a jump
    imem[8'h07] = 8'hC0;
    jumpTaken = 1'b1; jumpTarget = 8'h07;
    step();
    check_ifid("bubble", 8'h07, 8'hC5, 8'h41, 1'b0);
    check("bubble.ctrl", 16'(jumpIns_ctrl), 16'd0);
    jumpTaken = 1'b0;

    // Halt at PC=7
    step();
    check_ifid("halt", 8'h07, 8'hC0, 8'h07, 1'b1);
    check("halt.halted", 16'(halted), 16'd1);
    check("halt.ctrl", 16'(jumpIns_ctrl), 16'd0);
    check("halt.state", 16'(state_dbg), 16'd2);
    step();
    check_ifid("halt1", 8'h07, 8'hC0, 8'h07, 1'b0);
    check("halt1.halted", 16'(halted), 16'd1);
    stall = 1'b1;
    step();
    check_ifid("haltstall", 8'h07, 8'hC0, 8'h07, 1'b0);
    check("haltstall.halted", 16'(halted), 16'd1);
    stall = 1'b0;

    // Leave HALTED via jump to 0x20
    jumpTaken = 1'b1; jumpTarget = 8'h20;
    step();
    check_ifid("unhalt", 8'h20, 8'hC0, 8'h07, 1'b0);
    check("unhalt.halted", 16'(halted), 16'd0);
    jumpTaken = 1'b0;
    imem[8'h21] = 8'hC0;
    step();
    check_ifid("unhalt1", 8'h21, 8'h30, 8'h20, 1'b1);

    // Jump coincident with fetched halt: jump wins
    jumpTaken = 1'b1; jumpTarget = 8'hFE;
    step();
    check_ifid("jmphalt", 8'hFE, 8'h30, 8'h20, 1'b0);
    check("jmphalt.halted", 16'(halted), 16'd0);
    jumpTaken = 1'b0;

    // PC wrap FE, FF, 00
    step();
    check_ifid("wrapFE", 8'hFF, 8'h0E, 8'hFE, 1'b1);
    step();
    check_ifid("wrapFF", 8'h00, 8'h0F, 8'hFF, 1'b1);
    step();
    check_ifid("wrap00", 8'h01, 8'h10, 8'h00, 1'b1);

    // Asynchronous reset mid-sequence
    rst = 1'b1;
    #1;
    check_ifid("arst", 8'h00, 8'h00, 8'h00, 1'b0);
    check("arst.state", 16'(state_dbg), 16'd0);
    check("arst.ctrl", 16'(jumpIns_ctrl), 16'd0);
    step();
    rst = 1'b0;
    step();
    check_ifid("reboot", 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    check_ifid("refetch", 8'h01, 8'h10, 8'h00, 1'b1);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
